// File: rtl/rx_pkg.sv
// Shared definitions for the UART receive sequencer.
//   rx_state_t        : FSM state encoding used by rx_ctrl
//   DEF_CLKS_PER_BIT  : default clock cycles per bit period
//   DEF_NUM_BITS      : default bits shifted per frame (8 data + 1 stop)
package rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START_CHK,
      RECEIVE,
      STOP_CHK,
      LOAD
   } rx_state_t;

   localparam int DEF_CLKS_PER_BIT = 10;
   localparam int DEF_NUM_BITS     = 9;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timing counters for the UART receive sequencer.
//   clk        in  : system clock, rising edge
//   n_rst      in  : asynchronous active-low reset
//   clear      in  : zero both counters (wins over enable)
//   enable     in  : advance clk_cnt; bit_cnt advances when clk_cnt wraps
//   half_bit   out : clk_cnt is at the last cycle of a half bit period
//   bit_end    out : clk_cnt is at the last cycle of a full bit period
//   bits_done  out : bit_end for the final bit of the frame
module rx_bit_timer #(
   parameter int CLKS_PER_BIT = 10,
   parameter int NUM_BITS     = 9
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic half_bit,
   output logic bit_end,
   output logic bits_done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(NUM_BITS + 1);

   logic [CNT_W-1:0] clk_cnt_reg;
   logic [BIT_W-1:0] bit_cnt_reg;

   assign half_bit  = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT / 2 - 1));
   assign bit_end   = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
   assign bits_done = bit_end && (bit_cnt_reg == BIT_W'(NUM_BITS - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         clk_cnt_reg <= '0;
         bit_cnt_reg <= '0;
      end else if (clear) begin
         clk_cnt_reg <= '0;
         bit_cnt_reg <= '0;
      end else if (enable) begin
         if (bit_end) begin
            clk_cnt_reg <= '0;
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
         end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/rx_ctrl.sv
// UART receive sequencer: finds the start bit, confirms it at mid-bit,
// strobes the 9-bit shift register at every bit centre, checks the stop bit
// and either pulses load_buffer or sets the sticky framing error.
//   clk            in  : system clock, rising edge
//   n_rst          in  : asynchronous active-low reset
//   serial_in      in  : synchronized RX line, idle high
//   stop_bit       in  : MSB of the shift register, valid after the last strobe
//   shift_strobe   out : 1-cycle shift register enable at each bit centre
//   load_buffer    out : 1-cycle pulse, frame good, copy to RX buffer
//   framing_error  out : sticky, last frame had a low stop bit
//   rx_busy        out : high whenever the FSM is not idle
module rx_ctrl
   import rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int NUM_BITS     = DEF_NUM_BITS
) (
   input  logic clk,
   input  logic n_rst,
   input  logic serial_in,
   input  logic stop_bit,
   output logic shift_strobe,
   output logic load_buffer,
   output logic framing_error,
   output logic rx_busy
);

   rx_state_t state_reg, state_next;
   logic      prev_in_reg;
   logic      framing_error_reg, framing_error_next;
   logic      start_edge;
   logic      timer_clear, timer_enable;
   logic      half_bit, bit_end, bits_done;

   assign start_edge    = prev_in_reg & ~serial_in;
   assign framing_error = framing_error_reg;
   assign rx_busy       = (state_reg != IDLE);

   rx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .NUM_BITS     (NUM_BITS)
   ) u_timer (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (timer_clear),
      .enable    (timer_enable),
      .half_bit  (half_bit),
      .bit_end   (bit_end),
      .bits_done (bits_done)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg         <= IDLE;
         prev_in_reg       <= 1'b1;
         framing_error_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         prev_in_reg       <= serial_in;
         framing_error_reg <= framing_error_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      framing_error_next = framing_error_reg;
      timer_clear        = 1'b0;
      timer_enable       = 1'b0;
      shift_strobe       = 1'b0;
      load_buffer        = 1'b0;
      case (state_reg)
         IDLE: begin
            // Counters are held at zero while idle so the half-bit count
            // starts cleanly from the start edge.
            timer_clear = 1'b1;
            if (start_edge) begin
               state_next = START_CHK;
            end
         end
         START_CHK: begin
            timer_enable = 1'b1;
            if (half_bit) begin
               if (!serial_in) begin
                  // Start bit confirmed: realign to bit centres and
                  // forget the previous frame's error.
                  state_next         = RECEIVE;
                  timer_clear        = 1'b1;
                  framing_error_next = 1'b0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         RECEIVE: begin
            timer_enable = 1'b1;
            shift_strobe = bit_end;
            if (bits_done) begin
               state_next = STOP_CHK;
            end
         end
         STOP_CHK: begin
            if (stop_bit) begin
               state_next = LOAD;
            end else begin
               framing_error_next = 1'b1;
               state_next         = IDLE;
            end
         end
         LOAD: begin
            load_buffer = 1'b1;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rx_ctrl.sv
module tb_rx_ctrl;

   localparam int CPB = 10;
   localparam int NB  = 9;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic serial_in = 1'b1;
   logic stop_bit;
   logic shift_strobe, load_buffer, framing_error, rx_busy;

   logic [8:0] sr;
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int cur_e = 0;
   int busy_cnt = 0;
   int fe_clear_edge = -1;
   logic fe_prev;
   int strobe_q[$];
   int load_q[$];
   logic [8:0] load_data_q[$];

   rx_ctrl #(.CLKS_PER_BIT(CPB), .NUM_BITS(NB)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .serial_in     (serial_in),
      .stop_bit      (stop_bit),
      .shift_strobe  (shift_strobe),
      .load_buffer   (load_buffer),
      .framing_error (framing_error),
      .rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the external 9-bit shift register (LSB first).
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) sr <= '0;
      else if (shift_strobe) sr <= {serial_in, sr[8:1]};
   end
   assign stop_bit = sr[8];

   // Records the edge number that ends each pulse cycle.
   always @(negedge clk) begin
      if (shift_strobe) strobe_q.push_back(cyc + 1);
      if (load_buffer) begin
         load_q.push_back(cyc + 1);
         load_data_q.push_back(sr);
      end
      if (rx_busy) busy_cnt++;
      if (fe_prev === 1'b1 && framing_error === 1'b0) fe_clear_edge = cyc;
      fe_prev = framing_error;
   end

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic logic [8:0] dget(input logic [8:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 9'h000;
   endfunction

   task automatic clear_q();
      strobe_q.delete();
      load_q.delete();
      load_data_q.delete();
      busy_cnt = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called #1 after a posedge; the start edge is the next posedge.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      serial_in = 1'b0;
      cur_e = cyc + 1;
      for (int i = 0; i < 9; i++) begin
         repeat (CPB) @(posedge clk);
         #1;
         serial_in = (i < 8) ? d[i] : stop;
      end
      repeat (CPB) @(posedge clk);
      #1;
      serial_in = 1'b1;
      $display("[TB] frame data=%02h stop=%0b start_edge=%0d", d, stop, cur_e);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      tests++; if (shift_strobe !== 1'b0) begin fails++; $display("FAIL rst_strobe: got %b expected 0", shift_strobe); end
      tests++; if (load_buffer !== 1'b0) begin fails++; $display("FAIL rst_load: got %b expected 0", load_buffer); end
      tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL rst_fe: got %b expected 0", framing_error); end
      tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", rx_busy); end
      @(negedge clk);
      n_rst = 1'b1;
      clear_q();
      idle(50);
      tests++; if (strobe_q.size() != 0) begin fails++; $display("FAIL rst_idle_strobes: got %0d expected 0", strobe_q.size()); end
      tests++; if (load_q.size() != 0) begin fails++; $display("FAIL rst_idle_loads: got %0d expected 0", load_q.size()); end
      tests++; if (busy_cnt != 0) begin fails++; $display("FAIL rst_idle_busy: got %0d expected 0", busy_cnt); end
      $display("[TB] reset test done");
   endtask

   task automatic test_frame_a5();
      int e;
      clear_q();
      idle(5);
      send_frame(8'hA5, 1'b1);
      e = cur_e;
      idle(3);
      tests++; if (strobe_q.size() != 9) begin fails++; $display("FAIL a5_strobe_cnt: got %0d expected 9", strobe_q.size()); end
      for (int k = 0; k < 9; k++) begin
         tests++;
         if (qget(strobe_q, k) != e + 15 + 10 * k) begin
            fails++; $display("FAIL a5_strobe%0d_edge: got %0d expected %0d", k + 1, qget(strobe_q, k), e + 15 + 10 * k);
         end
      end
      tests++; if (load_q.size() != 1) begin fails++; $display("FAIL a5_load_cnt: got %0d expected 1", load_q.size()); end
      tests++; if (qget(load_q, 0) != e + 97) begin fails++; $display("FAIL a5_load_edge: got %0d expected %0d", qget(load_q, 0), e + 97); end
      tests++; if (dget(load_data_q, 0) !== 9'h1A5) begin fails++; $display("FAIL a5_data: got %03h expected 1a5", dget(load_data_q, 0)); end
      tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL a5_fe: got %b expected 0", framing_error); end
      tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL a5_busy_after: got %b expected 0", rx_busy); end
   endtask

   task automatic test_glitch();
      int e;
      clear_q();
      idle(5);
      serial_in = 1'b0;
      e = cyc + 1;
      repeat (3) @(posedge clk);
      #1;
      serial_in = 1'b1;
      @(negedge clk);
      tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_mid: got %b expected 1", rx_busy); end
      repeat (3) @(negedge clk);
      tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_e6: got %b expected 0 at edge %0d", rx_busy, e + 5); end
      idle(20);
      tests++; if (strobe_q.size() != 0) begin fails++; $display("FAIL glitch_strobes: got %0d expected 0", strobe_q.size()); end
      tests++; if (load_q.size() != 0) begin fails++; $display("FAIL glitch_loads: got %0d expected 0", load_q.size()); end
      tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL glitch_fe: got %b expected 0", framing_error); end
      $display("[TB] glitch start_edge=%0d busy_cycles=%0d", e, busy_cnt);
   endtask

   task automatic test_framing();
      int e;
      clear_q();
      idle(5);
      send_frame(8'h3C, 1'b0);
      idle(5);
      tests++; if (strobe_q.size() != 9) begin fails++; $display("FAIL fe_strobe_cnt: got %0d expected 9", strobe_q.size()); end
      tests++; if (load_q.size() != 0) begin fails++; $display("FAIL fe_load_cnt: got %0d expected 0", load_q.size()); end
      tests++; if (framing_error !== 1'b1) begin fails++; $display("FAIL fe_set: got %b expected 1", framing_error); end
      clear_q();
      fe_clear_edge = -1;
      send_frame(8'h81, 1'b1);
      e = cur_e;
      idle(3);
      tests++; if (fe_clear_edge != e + 5) begin fails++; $display("FAIL fe_clear_edge: got %0d expected %0d", fe_clear_edge, e + 5); end
      tests++; if (load_q.size() != 1) begin fails++; $display("FAIL fe_next_load_cnt: got %0d expected 1", load_q.size()); end
      tests++; if (dget(load_data_q, 0) !== 9'h181) begin fails++; $display("FAIL fe_next_data: got %03h expected 181", dget(load_data_q, 0)); end
   endtask

   task automatic test_back_to_back();
      int e1, e2;
      clear_q();
      idle(5);
      send_frame(8'h00, 1'b1);
      e1 = cur_e;
      send_frame(8'hFF, 1'b1);
      e2 = cur_e;
      idle(5);
      tests++; if (strobe_q.size() != 18) begin fails++; $display("FAIL b2b_strobe_cnt: got %0d expected 18", strobe_q.size()); end
      tests++; if (qget(strobe_q, 8) != e1 + 95) begin fails++; $display("FAIL b2b_f1_last: got %0d expected %0d", qget(strobe_q, 8), e1 + 95); end
      tests++; if (qget(strobe_q, 9) != e2 + 15) begin fails++; $display("FAIL b2b_f2_first: got %0d expected %0d", qget(strobe_q, 9), e2 + 15); end
      tests++; if (qget(strobe_q, 17) != e2 + 95) begin fails++; $display("FAIL b2b_f2_last: got %0d expected %0d", qget(strobe_q, 17), e2 + 95); end
      tests++; if (load_q.size() != 2) begin fails++; $display("FAIL b2b_load_cnt: got %0d expected 2", load_q.size()); end
      tests++; if (qget(load_q, 0) != e1 + 97) begin fails++; $display("FAIL b2b_load1_edge: got %0d expected %0d", qget(load_q, 0), e1 + 97); end
      tests++; if (qget(load_q, 1) != e2 + 97) begin fails++; $display("FAIL b2b_load2_edge: got %0d expected %0d", qget(load_q, 1), e2 + 97); end
      tests++; if (dget(load_data_q, 0) !== 9'h100) begin fails++; $display("FAIL b2b_data1: got %03h expected 100", dget(load_data_q, 0)); end
      tests++; if (dget(load_data_q, 1) !== 9'h1FF) begin fails++; $display("FAIL b2b_data2: got %03h expected 1ff", dget(load_data_q, 1)); end
   endtask

   task automatic test_reset_mid();
      int e;
      clear_q();
      idle(5);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (47) @(negedge clk);
            tests++; if (strobe_q.size() != 4) begin fails++; $display("FAIL rmid_pre_strobes: got %0d expected 4", strobe_q.size()); end
            n_rst = 1'b0;
            #1;
            tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b expected 0", rx_busy); end
            tests++; if (shift_strobe !== 1'b0) begin fails++; $display("FAIL rmid_strobe: got %b expected 0", shift_strobe); end
            tests++; if (load_buffer !== 1'b0) begin fails++; $display("FAIL rmid_load: got %b expected 0", load_buffer); end
            tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL rmid_fe: got %b expected 0", framing_error); end
            @(negedge clk);
            n_rst = 1'b1;
         end
      join
      idle(3);
      tests++; if (strobe_q.size() != 4) begin fails++; $display("FAIL rmid_post_strobes: got %0d expected 4", strobe_q.size()); end
      tests++; if (load_q.size() != 0) begin fails++; $display("FAIL rmid_post_loads: got %0d expected 0", load_q.size()); end
      clear_q();
      idle(5);
      send_frame(8'h5A, 1'b1);
      e = cur_e;
      idle(3);
      tests++; if (strobe_q.size() != 9) begin fails++; $display("FAIL rmid_next_strobes: got %0d expected 9", strobe_q.size()); end
      tests++; if (qget(strobe_q, 0) != e + 15) begin fails++; $display("FAIL rmid_next_first: got %0d expected %0d", qget(strobe_q, 0), e + 15); end
      tests++; if (qget(load_q, 0) != e + 97) begin fails++; $display("FAIL rmid_next_load_edge: got %0d expected %0d", qget(load_q, 0), e + 97); end
      tests++; if (dget(load_data_q, 0) !== 9'h15A) begin fails++; $display("FAIL rmid_next_data: got %03h expected 15a", dget(load_data_q, 0)); end
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
